stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset named `reset`.
REQ-002 The block SHALL have parameter DIV, default 5000000, giving the number of clock cycles per 0.1 s count tick; legal range is 2 or more.
REQ-003 The block SHALL have these ports:
- clock       in   1  system clock; all flops on rising edge
- reset       in   1  synchronous active-high reset
- start_stop  in   1  start/stop button, level, already synchronized
- clr         in   1  clear request, level
- up          in   1  direction request; 1 = count up, 0 = count down
- lap         in   1  lap button, level, already synchronized
- at_zero     in   1  datapath reads 0:00.0
- at_max      in   1  datapath reads 9:59.9
- cnt_en      out  1  one-cycle count strobe to datapath
- cnt_clr     out  1  one-cycle clear strobe to datapath
- cnt_load    out  1  one-cycle strobe to preload datapath with 9:59.9
- cnt_up      out  1  direction to datapath
- running     out  1  high in RUN
- done        out  1  high in DONE
- freeze      out  1  display hold (lap)

Function
REQ-004 start_stop SHALL be edge-detected against a registered copy: go = start_stop & ~start_stop_q. The same rule SHALL apply to lap.
REQ-005 The FSM states SHALL be IDLE, LOAD, RUN, PAUSE and DONE.
REQ-006 IDLE: on go with up=1, the FSM SHALL latch cnt_up=1 and go to RUN.
REQ-007 IDLE: on go with up=0, the FSM SHALL latch cnt_up=0; if at_zero=1 it SHALL go to LOAD, otherwise to RUN.
REQ-008 LOAD SHALL last exactly one cycle, SHALL assert cnt_load=1 during that cycle, and SHALL then go to RUN.
REQ-009 cnt_up SHALL change only on leaving IDLE; changes on `up` outside IDLE SHALL be ignored.
REQ-010 RUN prescaler: counts 0..DIV-1 and wraps. On the cycle it equals DIV-1, cnt_en SHALL be 1 for exactly that one cycle. First cnt_en comes DIV cycles after entering RUN from IDLE/LOAD.
REQ-011 RUN: on go, the FSM SHALL go to PAUSE. The prescaler SHALL hold its value and cnt_en SHALL stay 0.
REQ-012 PAUSE: on go, the FSM SHALL return to RUN and the prescaler SHALL resume from the held value.
REQ-013 Terminal: in RUN, when the prescaler equals DIV-1 and either (cnt_up & at_max) or (~cnt_up & at_zero) is true:
- cnt_en SHALL be suppressed;
- the FSM SHALL go to DONE.
REQ-014 DONE: done SHALL be 1 and go SHALL be ignored; only clr or reset SHALL leave DONE.
REQ-015 clr=1 in any state SHALL:
- drive cnt_clr=1 for that cycle;
- clear the prescaler;
- go to IDLE next cycle.
cnt_clr SHALL repeat every cycle while clr is held.
REQ-016 If clr and go occur in the same cycle, clr SHALL win and go SHALL be discarded.
REQ-017 If clr occurs in LOAD, the FSM SHALL assert cnt_clr and not cnt_load, then go to IDLE.
REQ-018 All outputs SHALL be registered or decoded from state only: running = (state==RUN), done = (state==DONE).

Reset
REQ-019 Reset SHALL force: state=IDLE, prescaler=0, cnt_en=0, cnt_clr=0, cnt_load=0, cnt_up=1, freeze=0.
REQ-020 Reset SHALL set start_stop_q=1 and lap_q=1, so a button held through reset produces no edge.
REQ-021 Reset SHALL take priority over clr and all other inputs.

Configuration
REQ-022 With STOPWATCH_CTRL_LAP_EN defined, a lap edge in RUN or PAUSE SHALL toggle freeze. freeze SHALL clear on clr, on reset and on entering IDLE, and lap edges SHALL be ignored in IDLE, LOAD and DONE.
REQ-023 Without STOPWATCH_CTRL_LAP_EN, freeze SHALL be constant 0 and lap SHALL be ignored; the port list SHALL be unchanged.

Verification (DIV=4)
REQ-024 Up count:
- stimulus: reset, then up=1 and a start_stop pulse;
- response: running=1 one cycle after the edge and cnt_en pulses every 4 cycles, first 4 cycles after entry;
- then: a second pulse gives PAUSE, no cnt_en for 20 cycles, and a third pulse resumes with the prescaler phase preserved.
REQ-025 Down from zero:
- stimulus: up=0, at_zero=1, start_stop pulse;
- response: one cnt_load cycle, then RUN with cnt_up=0;
- then: force at_zero=1 at a prescaler wrap, giving no cnt_en that cycle, DONE with done=1, and further start_stop pulses ignored.
REQ-026 Up terminal: at_max=1 in RUN at a prescaler wrap -> DONE with no cnt_en; then clr=1 -> cnt_clr=1 for 1 cycle, then IDLE with done=0.
REQ-027 Simultaneous events: clr and a start_stop edge in the same RUN cycle -> cnt_clr=1, IDLE next cycle, no PAUSE. Toggling up during RUN leaves cnt_up unchanged.
REQ-028 Reset and lap:
- start_stop held high through reset release -> FSM stays IDLE;
- with LAP_EN: lap pulses in RUN give freeze 0->1->0, and clr forces freeze=0;
- without LAP_EN: freeze stays 0 throughout.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: start/stop/pause, preload for count-down, terminal detect.
// Optional lap/freeze behaviour enabled by defining STOPWATCH_CTRL_LAP_EN.
module stopwatch_ctrl #(
    parameter int unsigned DIV = 5000000
) (
    input  logic clock,
    input  logic reset,
    input  logic start_stop,
    input  logic clr,
    input  logic up,
    input  logic lap,
    input  logic at_zero,
    input  logic at_max,
    output logic cnt_en,
    output logic cnt_clr,
    output logic cnt_load,
    output logic cnt_up,
    output logic running,
    output logic done,
    output logic freeze
);

    localparam int unsigned PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        PAUSE,
        DONE
    } state_e;

    state_e state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic ss_q;
    logic cnt_up_q, cnt_up_d;
    logic freeze_q, freeze_d;
    logic go, wrap, term;

    assign go   = start_stop & ~ss_q;
    assign wrap = (pre_q == LAST);
    assign term = cnt_up_q ? at_max : at_zero;

`ifdef STOPWATCH_CTRL_LAP_EN
    logic lap_q;
    logic lap_go;

    assign lap_go = lap & ~lap_q;

    // Reset high so a lap button held through reset yields no edge
    always_ff @(posedge clock) begin
        if (reset) lap_q <= 1'b1;
        else       lap_q <= lap;
    end
`else
    logic unused_lap;
    assign unused_lap = lap;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            pre_q    <= '0;
            ss_q     <= 1'b1;
            cnt_up_q <= 1'b1;
            freeze_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            ss_q     <= start_stop;
            cnt_up_q <= cnt_up_d;
            freeze_q <= freeze_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        cnt_up_d = cnt_up_q;
        if (clr) begin
            state_d = IDLE;
            pre_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    pre_d = '0;
                    if (go) begin
                        cnt_up_d = up;
                        state_d  = (!up && at_zero) ? LOAD : RUN;
                    end
                end
                LOAD: begin
                    pre_d   = '0;
                    state_d = RUN;
                end
                RUN: begin
                    // A pause press freezes the prescaler phase in place
                    if (go) begin
                        state_d = PAUSE;
                    end else if (wrap) begin
                        pre_d = '0;
                        if (term) state_d = DONE;
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end
                PAUSE: begin
                    if (go) state_d = RUN;
                end
                DONE: begin
                    pre_d = '0;
                end
                default: begin
                    state_d = IDLE;
                    pre_d   = '0;
                end
            endcase
        end

`ifdef STOPWATCH_CTRL_LAP_EN
        freeze_d = freeze_q;
        if (clr || state_d == IDLE) begin
            freeze_d = 1'b0;
        end else if (lap_go && (state_q == RUN || state_q == PAUSE)) begin
            freeze_d = ~freeze_q;
        end
`else
        freeze_d = 1'b0;
`endif
    end

    always_comb begin
        cnt_en   = 1'b0;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        if (!reset) begin
            cnt_clr  = clr;
            cnt_load = (state_q == LOAD) && !clr;
            cnt_en   = (state_q == RUN) && !clr && !go && wrap && !term;
        end
        cnt_up  = cnt_up_q;
        running = (state_q == RUN);
        done    = (state_q == DONE);
        freeze  = freeze_q;
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Testbench for stopwatch_ctrl with DIV=4: directed vector table, pause
// sequence, and randomized run against a behavioural model.
module tb_stopwatch_ctrl;

    localparam int DIV = 4;
`ifdef STOPWATCH_CTRL_LAP_EN
    localparam bit LAPV = 1'b1;
`else
    localparam bit LAPV = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset, start_stop, clr, up, lap, at_zero, at_max;
    logic cnt_en, cnt_clr, cnt_load, cnt_up, running, done, freeze;

    int checks = 0;
    int failures = 0;

    stopwatch_ctrl #(.DIV(DIV)) dut (
        .clock(clock), .reset(reset), .start_stop(start_stop), .clr(clr),
        .up(up), .lap(lap), .at_zero(at_zero), .at_max(at_max),
        .cnt_en(cnt_en), .cnt_clr(cnt_clr), .cnt_load(cnt_load),
        .cnt_up(cnt_up), .running(running), .done(done), .freeze(freeze)
    );

    always #5 clock = ~clock;

    // inputs  {reset, start_stop, clr, up, lap, at_zero, at_max}
    // outputs {cnt_en, cnt_clr, cnt_load, cnt_up, running, done, freeze}
    typedef struct {
        logic [6:0] in;
        logic [6:0] exp;
        logic       fzl;
    } vec_t;

    vec_t tbl [0:48];

    typedef enum {M_IDLE, M_LOAD, M_RUN, M_PAUSE, M_DONE} mode_e;
    mode_e m_mode = M_IDLE;
    int    m_phase = 0;
    bit    m_up = 1'b1, m_fz = 1'b0, m_ssq = 1'b1, m_lapq = 1'b1;
    logic [6:0] m_exp;

    function automatic logic [6:0] model_out(logic [6:0] in);
        bit r, ss, c, az, am, go, term, wrap, en, cl, ld;
        r  = in[6]; ss = in[5]; c = in[4]; az = in[1]; am = in[0];
        go   = ss && !m_ssq;
        term = m_up ? am : az;
        wrap = (m_phase == DIV - 1);
        en = !r && (m_mode == M_RUN) && !c && !go && wrap && !term;
        cl = !r && c;
        ld = !r && (m_mode == M_LOAD) && !c;
        return {en, cl, ld, m_up, m_mode == M_RUN, m_mode == M_DONE, m_fz};
    endfunction

    task automatic model_step(input logic [6:0] in);
        bit r, ss, c, u, l, az, am, go, lgo, term;
        r = in[6]; ss = in[5]; c = in[4]; u = in[3]; l = in[2];
        az = in[1]; am = in[0];
        if (r) begin
            m_mode = M_IDLE; m_phase = 0; m_up = 1'b1; m_fz = 1'b0;
            m_ssq = 1'b1; m_lapq = 1'b1;
            return;
        end
        go   = ss && !m_ssq;
        lgo  = l && !m_lapq;
        term = m_up ? am : az;
        if (LAPV && lgo && (m_mode == M_RUN || m_mode == M_PAUSE)) m_fz = !m_fz;
        if (c) begin
            m_mode = M_IDLE; m_phase = 0; m_fz = 1'b0;
        end else begin
            case (m_mode)
                M_IDLE: if (go) begin
                    m_up = u; m_phase = 0;
                    m_mode = (!u && az) ? M_LOAD : M_RUN;
                end
                M_LOAD: m_mode = M_RUN;
                M_RUN: if (go) m_mode = M_PAUSE;
                       else begin
                           if (m_phase == DIV - 1 && term) m_mode = M_DONE;
                           m_phase = (m_phase + 1) % DIV;
                       end
                M_PAUSE: if (go) m_mode = M_RUN;
                default: ;
            endcase
        end
        m_ssq = ss; m_lapq = l;
    endtask

    task automatic cyc(input logic [6:0] in, output logic [6:0] act);
        @(negedge clock);
        {reset, start_stop, clr, up, lap, at_zero, at_max} = in;
        #1;
        m_exp = model_out(in);
        act = {cnt_en, cnt_clr, cnt_load, cnt_up, running, done, freeze};
        @(posedge clock);
        model_step(in);
    endtask

    task automatic chk(input string name, input logic [6:0] got, input logic [6:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%b want=%b", name, got, want);
        end
    endtask

    initial begin
        logic [6:0] act;
        logic [6:0] in;
        bit ss_l, lap_l;
        int k;

        tbl = '{
            '{7'b1110000, 7'b0001000, 1'b0}, '{7'b0101000, 7'b0001000, 1'b0},
            '{7'b0101000, 7'b0001000, 1'b0}, '{7'b0001000, 7'b0001000, 1'b0},
            '{7'b0101000, 7'b0001000, 1'b0}, '{7'b0001000, 7'b0001100, 1'b0},
            '{7'b0001000, 7'b0001100, 1'b0}, '{7'b0001000, 7'b0001100, 1'b0},
            '{7'b0001000, 7'b1001100, 1'b0}, '{7'b0000000, 7'b0001100, 1'b0},
            '{7'b0000000, 7'b0001100, 1'b0}, '{7'b0100000, 7'b0001100, 1'b0},
            '{7'b0000000, 7'b0001000, 1'b0}, '{7'b0100000, 7'b0001000, 1'b0},
            '{7'b0000000, 7'b0001100, 1'b0}, '{7'b0000000, 7'b1001100, 1'b0},
            '{7'b0110000, 7'b0101100, 1'b0}, '{7'b0000000, 7'b0001000, 1'b0},
            '{7'b0100010, 7'b0001000, 1'b0}, '{7'b0000010, 7'b0010000, 1'b0},
            '{7'b0000000, 7'b0000100, 1'b0}, '{7'b0000000, 7'b0000100, 1'b0},
            '{7'b0000000, 7'b0000100, 1'b0}, '{7'b0000010, 7'b0000100, 1'b0},
            '{7'b0100000, 7'b0000010, 1'b0}, '{7'b0000000, 7'b0000010, 1'b0},
            '{7'b0100000, 7'b0000010, 1'b0}, '{7'b0010000, 7'b0100010, 1'b0},
            '{7'b0010000, 7'b0100000, 1'b0}, '{7'b0000000, 7'b0000000, 1'b0},
            '{7'b0101000, 7'b0000000, 1'b0}, '{7'b0001000, 7'b0001100, 1'b0},
            '{7'b0001000, 7'b0001100, 1'b0}, '{7'b0001000, 7'b0001100, 1'b0},
            '{7'b0001001, 7'b0001100, 1'b0}, '{7'b0001000, 7'b0001010, 1'b0},
            '{7'b0011000, 7'b0101010, 1'b0}, '{7'b0001000, 7'b0001000, 1'b0},
            '{7'b0100010, 7'b0001000, 1'b0}, '{7'b0010000, 7'b0100000, 1'b0},
            '{7'b0000000, 7'b0000000, 1'b0}, '{7'b0101000, 7'b0000000, 1'b0},
            '{7'b0001100, 7'b0001100, 1'b0}, '{7'b0001000, 7'b0001100, 1'b1},
            '{7'b0001100, 7'b0001100, 1'b1}, '{7'b0001000, 7'b1001100, 1'b0},
            '{7'b0001100, 7'b0001100, 1'b0}, '{7'b0011000, 7'b0101100, 1'b1},
            '{7'b0001000, 7'b0001000, 1'b0}
        };

        // start_stop held high through reset
        repeat (2) cyc(7'b1100000, act);

        for (int i = 0; i <= 48; i++) begin
            cyc(tbl[i].in, act);
            chk($sformatf("vec%0d", i), act, tbl[i].exp | {6'b0, tbl[i].fzl & LAPV});
        end

        // Pause for 20 cycles, then confirm the prescaler phase survives
        cyc(7'b0101000, act);
        repeat (6) cyc(7'b0001000, act);
        cyc(7'b0101000, act);
        for (int i = 0; i < 20; i++) begin
            cyc(7'b0001000, act);
            chk("pause_hold", act & 7'b1000100, 7'b0);
        end
        cyc(7'b0101000, act);
        k = 9;
        for (int i = 1; i <= 8; i++) begin
            cyc(7'b0001000, act);
            if (act[6]) begin
                k = i;
                break;
            end
        end
        checks++;
        if (k != 2) begin
            failures++;
            $display("FAIL resume_phase got=%0d want=2", k);
        end
        cyc(7'b0011000, act);

        ss_l = 1'b0;
        lap_l = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom % 3 == 0) ss_l = !ss_l;
            if ($urandom % 3 == 0) lap_l = !lap_l;
            in = {($urandom % 250) == 0, ss_l, ($urandom % 40) == 0,
                  1'($urandom % 2), lap_l,
                  ($urandom % 5) == 0, ($urandom % 5) == 0};
            cyc(in, act);
            chk($sformatf("rand%0d", i), act, m_exp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
